time_nmr_start: RTL and testbench

- Upstream-side splitter for time-based N-modular redundancy.
- Each accepted input item is re-issued downstream NumReps times back-to-back, with the same ID on every copy and a replica index per copy.
- Sits in front of a replicated-in-time pipeline and pairs with a matching N-way time-redundancy end/voter block.
- Generalises fixed-count dual replication to any count from 1 to 7, and adds a per-item enable latch, replica-index output and an abort input.

---
 rtl/time_redundancy_pkg.sv | 40 ++++
 rtl/time_id_gen.sv | 31 +++
 rtl/time_nmr_start.sv | 149 ++++++++++++++
 tb/tb_time_nmr_start.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/time_redundancy_pkg.sv
// time_redundancy_pkg
//   Shared definitions for the time-redundancy start/end blocks.
//   - nmr_start_state_t : splitter FSM states
//   - MaxNumReps        : largest supported replication count
//   - MaxIdSize         : widest ID handled by id_next()
//   - id_next()         : parity-protected ID increment. The low id_size-1 bits
//                         count modulo 2^(id_size-1); bit id_size-1 carries
//                         the XOR of the count bits. Bits above id_size are 0.
package time_redundancy_pkg;

  localparam int MaxNumReps = 7;
  localparam int MaxIdSize  = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    REPLICATE = 2'd2
  } nmr_start_state_t;

  function automatic logic [MaxIdSize-1:0] id_next(input logic [MaxIdSize-1:0] id,
                                                   input int id_size);
    logic [MaxIdSize-1:0] inc;
    logic [MaxIdSize-1:0] r;
    logic                 p;
    inc = id + 1'b1;
    r   = '0;
    p   = 1'b0;
    for (int i = 0; i < MaxIdSize; i++) begin
      if (i < id_size - 1) begin
        r[i] = inc[i];
        p    = p ^ inc[i];
      end
    end
    for (int i = 0; i < MaxIdSize; i++) begin
      if (i == id_size - 1) r[i] = p;
    end
    return r;
  endfunction

endpackage

// File: rtl/time_id_gen.sv
// time_id_gen
//   Produces the ID the next item will receive: either the parity-protected
//   increment of the current ID, or an externally supplied ID.
//   Ports:
//     cur_id  in  IDSize  last assigned ID
//     ext_id  in  IDSize  external ID (selected when UseExternalId=1)
//     next_id out IDSize  ID for the next accepted item
module time_id_gen
  import time_redundancy_pkg::*;
#(
  parameter int IDSize        = 2,
  parameter bit UseExternalId = 1'b0
) (
  input  logic [IDSize-1:0] cur_id,
  input  logic [IDSize-1:0] ext_id,
  output logic [IDSize-1:0] next_id
);

  logic [MaxIdSize-1:0] nxt_full;

  assign nxt_full = id_next(MaxIdSize'(cur_id), IDSize);
  assign next_id  = UseExternalId ? ext_id : nxt_full[IDSize-1:0];

  // Upper bits are always zero; they exist only because the shared function
  // works at a fixed width.
  if (IDSize < MaxIdSize) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^nxt_full[MaxIdSize-1:IDSize];
  end

endmodule

// File: rtl/time_nmr_start.sv
// time_nmr_start
//   Upstream splitter for time-based N-modular redundancy. Each accepted item
//   is re-issued NumReps times back-to-back (1 time when enable_i is low at
//   accept), carrying the same ID and a replica index. The first copy passes
//   through combinationally.
//   Ports:
//     clk_i, rst_i (async, active-high)
//     enable_i   redundancy enable, latched per accepted item
//     abort_i    drops pending replicas (HOLD/REPLICATE only)
//     next_id_o  ID the next accepted item will get
//     data_i, id_i, valid_i, ready_o        upstream handshake
//     data_o, id_o, rep_o, last_o, valid_o, ready_i  downstream handshake
//   Optional: define TIME_NMR_START_ASSERT_EN to compile in protocol assertions.
module time_nmr_start
  import time_redundancy_pkg::*;
#(
  parameter type DataType      = logic,
  parameter int  NumReps       = 3,
  parameter int  IDSize        = 2,
  parameter bit  UseExternalId = 1'b0,
  parameter int  RepWidth      = (NumReps > 2) ? $clog2(NumReps) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                abort_i,
  output logic [IDSize-1:0]   next_id_o,
  input  DataType             data_i,
  input  logic [IDSize-1:0]   id_i,
  input  logic                valid_i,
  output logic                ready_o,
  output DataType             data_o,
  output logic [IDSize-1:0]   id_o,
  output logic [RepWidth-1:0] rep_o,
  output logic                last_o,
  output logic                valid_o,
  input  logic                ready_i
);

  if (NumReps < 1 || NumReps > MaxNumReps) begin : g_bad_reps
    $error("time_nmr_start: NumReps must be within 1..7");
  end
  if (IDSize < 2 || IDSize > MaxIdSize) begin : g_bad_id
    $error("time_nmr_start: IDSize must be within 2..16");
  end

  localparam logic [RepWidth-1:0] RepMax = RepWidth'(NumReps - 1);

  nmr_start_state_t    state_q;
  DataType             data_q;
  logic [IDSize-1:0]   id_q;
  logic [RepWidth-1:0] rep_q;
  logic                en_q;

  logic [RepWidth-1:0] tgt_live, tgt_q;

  time_id_gen #(
    .IDSize       (IDSize),
    .UseExternalId(UseExternalId)
  ) u_id_gen (
    .cur_id (id_q),
    .ext_id (id_i),
    .next_id(next_id_o)
  );

  // Live target governs the pass-through copy; latched target governs the rest.
  assign tgt_live = enable_i ? RepMax : '0;
  assign tgt_q    = en_q     ? RepMax : '0;

  always_comb begin
    if (state_q == IDLE) begin
      ready_o = 1'b1;
      valid_o = valid_i;
      data_o  = data_i;
      id_o    = next_id_o;
      rep_o   = '0;
      last_o  = (tgt_live == '0);
    end else begin
      ready_o = 1'b0;
      valid_o = 1'b1;
      data_o  = data_q;
      id_o    = id_q;
      rep_o   = rep_q;
      last_o  = (rep_q == tgt_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      id_q    <= '0;
      rep_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            data_q <= data_i;
            id_q   <= next_id_o;
            en_q   <= enable_i;
            if (!ready_i) begin
              // original copy not yet taken: replay it from the registers
              state_q <= HOLD;
              rep_q   <= '0;
            end else if (tgt_live != '0) begin
              state_q <= REPLICATE;
              rep_q   <= RepWidth'(1);
            end else begin
              rep_q <= '0;
            end
          end
        end
        HOLD, REPLICATE: begin
          // id_q is kept on abort so the next item still gets a fresh ID
          if (abort_i) begin
            state_q <= IDLE;
            rep_q   <= '0;
          end else if (ready_i) begin
            if (rep_q == tgt_q) begin
              state_q <= IDLE;
              rep_q   <= '0;
            end else begin
              state_q <= REPLICATE;
              rep_q   <= rep_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          rep_q   <= '0;
        end
      endcase
    end
  end

`ifdef TIME_NMR_START_ASSERT_EN
  a_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i && state_q != IDLE && !abort_i) |=>
      ($stable(data_o) && $stable(id_o) && $stable(rep_o)));
  a_rep_range: assert property (@(posedge clk_i) disable iff (rst_i)
    rep_o <= RepMax);
  a_ready_low: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q != IDLE) |-> !ready_o);
  a_parity: assert property (@(posedge clk_i) disable iff (rst_i)
    (!UseExternalId) |-> (id_o[IDSize-1] == ^id_o[IDSize-2:0]));
`endif

endmodule

// File: tb/tb_time_nmr_start.sv
// tb_time_nmr_start
//   Randomised and directed stimulus against a queue-based reference model:
//   each accepted item expands into a list of beats; the head beat is what
//   the DUT must present. A second instance checks external-ID mode.
module tb_time_nmr_start;
  localparam int NR  = 3;
  localparam int IDS = 2;
  localparam int RW  = 2;

  logic           clk = 1'b0;
  logic           rst_i, enable_i, abort_i, valid_i, ready_i;
  logic [7:0]     data_i;
  logic [IDS-1:0] id_i;
  logic [IDS-1:0] next_id_o, id_o, next_id2, id2;
  logic [7:0]     data_o, data2;
  logic [RW-1:0]  rep_o, rep2;
  logic           ready_o, last_o, valid_o, ready2, last2, valid2;

  always #5 clk = ~clk;

  time_nmr_start #(.DataType(logic [7:0]), .NumReps(NR), .IDSize(IDS), .UseExternalId(1'b0)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .abort_i(abort_i), .next_id_o(next_id_o),
    .data_i(data_i), .id_i(id_i), .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o),
    .id_o(id_o), .rep_o(rep_o), .last_o(last_o), .valid_o(valid_o), .ready_i(ready_i));

  time_nmr_start #(.DataType(logic [7:0]), .NumReps(NR), .IDSize(IDS), .UseExternalId(1'b1)) dut_ext (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .abort_i(abort_i), .next_id_o(next_id2),
    .data_i(data_i), .id_i(id_i), .valid_i(valid_i), .ready_o(ready2), .data_o(data2),
    .id_o(id2), .rep_o(rep2), .last_o(last2), .valid_o(valid2), .ready_i(ready_i));

  typedef struct {
    logic [7:0]     d;
    logic [IDS-1:0] id;
    logic [IDS-1:0] eid;
    int             rep;
    logic           last;
  } beat_t;

  beat_t q[$];
  int    last_cnt;
  int    nchk = 0;
  int    nerr = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [IDS-1:0] mk_id(input int c);
    logic [IDS-2:0] cc;
    cc = c[IDS-2:0];
    return {^cc, cc};
  endfunction

  task automatic check_outputs();
    if (q.size() == 0) begin
      chk("valid", 32'(valid_o), 32'(valid_i));
      chk("ready", 32'(ready_o), 32'd1);
      chk("data",  32'(data_o),  32'(data_i));
      chk("id",    32'(id_o),    32'(mk_id(last_cnt + 1)));
      chk("next_id", 32'(next_id_o), 32'(mk_id(last_cnt + 1)));
      chk("rep",   32'(rep_o),   32'd0);
      chk("last",  32'(last_o),  32'(!enable_i));
      chk("ext_id", 32'(id2),    32'(id_i));
    end else begin
      chk("valid", 32'(valid_o), 32'd1);
      chk("ready", 32'(ready_o), 32'd0);
      chk("data",  32'(data_o),  32'(q[0].d));
      chk("id",    32'(id_o),    32'(q[0].id));
      chk("rep",   32'(rep_o),   32'(q[0].rep));
      chk("last",  32'(last_o),  32'(q[0].last));
      chk("ext_id", 32'(id2),    32'(q[0].eid));
    end
    chk("ext_valid", 32'(valid2), 32'(valid_o === 1'b1 ? 1 : 0) & 32'(q.size() != 0 || valid_i));
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic en,
                      input logic rdy, input logic ab, input logic [IDS-1:0] eid);
    int n;
    @(negedge clk);
    valid_i = v; data_i = d; enable_i = en; ready_i = rdy; abort_i = ab; id_i = eid;
    #1;
    check_outputs();
    @(posedge clk);
    if (q.size() == 0) begin
      if (v) begin
        last_cnt = (last_cnt + 1) % (1 << (IDS - 1));
        n = en ? NR : 1;
        for (int r = 0; r < n; r++) q.push_back('{d, mk_id(last_cnt), eid, r, (r == n - 1)});
        if (rdy) void'(q.pop_front());
      end
    end else if (ab) begin
      q.delete();
    end else if (rdy) begin
      void'(q.pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; valid_i = 1'b1; enable_i = 1'b1;
    q.delete();
    last_cnt = 0;
    #1;
    chk("rst_valid", 32'(valid_o), 32'd1);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_rep",   32'(rep_o),   32'd0);
    chk("rst_id",    32'(id_o),    32'(mk_id(1)));
    @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; abort_i = 1'b0; valid_i = 1'b0;
    ready_i = 1'b1; data_i = '0; id_i = '0;
    last_cnt = 0;
    do_reset();

    // three copies of 0xA5
    step(1, 8'hA5, 1, 1, 0, 2'b01);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 1, 0, 2'b00);
    // single-copy back-to-back
    step(1, 8'h01, 0, 1, 0, 2'b10);
    step(1, 8'h02, 0, 1, 0, 2'b01);
    step(1, 8'h03, 0, 1, 0, 2'b11);
    // downstream stall after accept
    step(1, 8'h3C, 1, 0, 0, 2'b10);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0, 2'b00);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 1, 0, 2'b00);
    // enable drops during rep 1
    step(1, 8'h55, 1, 1, 0, 2'b00);
    step(0, 8'h00, 0, 1, 0, 2'b00);
    step(0, 8'h00, 0, 1, 0, 2'b00);
    step(1, 8'h66, 0, 1, 0, 2'b01);
    // abort during rep 1
    step(1, 8'h77, 1, 1, 0, 2'b11);
    step(0, 8'h00, 1, 1, 1, 2'b00);
    step(1, 8'h88, 1, 1, 0, 2'b10);
    step(0, 8'h00, 1, 1, 0, 2'b00);
    step(0, 8'h00, 1, 1, 0, 2'b00);
    // reset mid-item
    step(1, 8'h99, 1, 1, 0, 2'b10);
    do_reset();
    step(1, 8'hAB, 1, 1, 0, 2'b10);
    step(0, 8'h00, 1, 1, 0, 2'b00);
    step(0, 8'h00, 1, 1, 0, 2'b00);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), 2'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
